// File: rtl/spi_flash_rd_wb.sv
// Read-only Wishbone slave: every word read becomes one SPI READ (0x03) transaction
// (command, 24-bit byte address, four data bytes) on an SPI mode-0 serial flash.
module spi_flash_rd_wb #(
  parameter int CLK_DIV  = 1,
  parameter int FLASH_AW = 24
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_w,
  input  logic [3:0]  wb_sel,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  output logic [31:0] wb_dat_r,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        flash_sck,
  output logic        flash_csn,
  output logic        flash_sdo,
  input  logic        flash_sdi
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1'b1);
  localparam logic [6:0]       BIT_LAST = 7'd63;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t           state_r;
  logic [DIV_W-1:0] div_r;
  logic [6:0]       bit_r;
  logic [31:0]      shift_r;
  logic [31:0]      rx_r;
  logic [31:0]      cmd_s;
  logic             req_s;
  logic             unused_s;

  // The flash returns the lowest-addressed byte first; the bus word is little-endian.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign req_s    = wb_cyc & wb_stb & ~wb_ack & ~wb_err;
  assign cmd_s    = {8'h03, wb_adr[FLASH_AW-1:2], 2'b00};
  assign unused_s = ^{wb_dat_w, wb_sel, wb_adr[31:FLASH_AW], wb_adr[1:0]};

  // Transaction sequencer: bus handshake, SCK/CSN generation and both shift registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      div_r     <= '0;
      bit_r     <= 7'd0;
      shift_r   <= 32'h0;
      rx_r      <= 32'h0;
      wb_dat_r  <= 32'h0;
      wb_ack    <= 1'b0;
      wb_err    <= 1'b0;
      flash_sck <= 1'b0;
      flash_csn <= 1'b1;
      flash_sdo <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          wb_ack <= 1'b0;
          wb_err <= 1'b0;
          if (req_s && wb_we) begin
            wb_err  <= 1'b1;
            state_r <= ERR;
          end else if (req_s) begin
            // First bit goes out together with the CSN fall; shift_r holds the rest.
            flash_sdo <= cmd_s[31];
            shift_r   <= {cmd_s[30:0], 1'b0};
            flash_csn <= 1'b0;
            flash_sck <= 1'b0;
            div_r     <= '0;
            bit_r     <= 7'd0;
            state_r   <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          if (!wb_cyc) begin
            flash_csn <= 1'b1;
            flash_sck <= 1'b0;
            flash_sdo <= 1'b0;
            state_r   <= IDLE;
          end else if (div_r != DIV_LAST) begin
            div_r <= div_r + DIV_ONE;
          end else begin
            div_r <= '0;
            if (!flash_sck) begin
              flash_sck <= 1'b1;
              rx_r      <= {rx_r[30:0], flash_sdi};
            end else if (bit_r == BIT_LAST) begin
              flash_sck <= 1'b0;
              flash_csn <= 1'b1;
              flash_sdo <= 1'b0;
              wb_ack    <= 1'b1;
              wb_dat_r  <= byte_swap(rx_r);
              state_r   <= DONE;
            end else begin
              flash_sck <= 1'b0;
              flash_sdo <= shift_r[31];
              shift_r   <= {shift_r[30:0], 1'b0};
              bit_r     <= bit_r + 7'd1;
            end
          end
        end
        DONE: begin
          wb_ack  <= 1'b0;
          state_r <= IDLE;
        end
        ERR: begin
          wb_err  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          flash_csn <= 1'b1;
          flash_sck <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule
